pid_loop_filter: RTL and testbench

//  Parametrised PI loop filter for the GPSDO OCXO steering path. Takes each signed phase error from the phase meter
//  (one-cycle Measure_Done strobe) and computes a saturated PWM duty with anti-windup.

---
 rtl/pid_pkg.sv | 32 +++
 rtl/pid_loop_filter_if.sv | 12 +
 rtl/pid_lock_detect.sv | 53 +++++
 rtl/pid_loop_filter.sv | 181 ++++++++++++++++++
 tb/tb_pid_loop_filter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/pid_pkg.sv
// Shared constants and FSM encoding for the GPSDO PI loop filter.
// The PWM generator and the bench import the same package.
package pid_pkg;

  localparam int DEF_PHASE_W         = 24;
  localparam int DEF_DUTY_W          = 16;
  localparam int DEF_DUTY_CENTER     = 35000;
  localparam int DEF_DUTY_MIN        = 1000;
  localparam int DEF_DUTY_MAX        = 64000;
  localparam int DEF_KP_SHIFT        = 4;
  localparam int DEF_KP_COARSE_SHIFT = 2;
  localparam int DEF_KI_SHIFT        = 8;
  localparam int DEF_ERR_CLAMP       = 1048575;
  localparam int DEF_COARSE_TH       = 5000000;
  localparam int DEF_LOCK_TH         = 100;
  localparam int DEF_UNLOCK_TH       = 1000;
  localparam int DEF_LOCK_CNT        = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLAMP = 3'd1,
    ST_INTEG = 3'd2,
    ST_SUM   = 3'd3,
    ST_OUT   = 3'd4
  } pid_state_e;

  // Two guard bits let the integrator reach +/-2 full duty ranges before it saturates.
  function automatic int acc_width(input int duty_w, input int ki_shift);
    return duty_w + ki_shift + 2;
  endfunction

endpackage

// File: rtl/pid_loop_filter_if.sv
// Phase-meter to loop-filter measurement link: signed error plus a one-cycle strobe.
interface pid_loop_filter_if #(
  parameter int PHASE_W = pid_pkg::DEF_PHASE_W
) ();

  logic signed [PHASE_W-1:0] Measure_Phase;
  logic                      Measure_Done;

  modport master (output Measure_Phase, output Measure_Done);
  modport slave  (input  Measure_Phase, input  Measure_Done);

endinterface

// File: rtl/pid_lock_detect.sv
// Lock detector: counts consecutive in-window samples, drops on large error,
// and holds its state in the hysteresis band between the two thresholds.
module pid_lock_detect
  import pid_pkg::*;
#(
  parameter int ABS_W     = DEF_PHASE_W + 1,
  parameter int LOCK_TH   = DEF_LOCK_TH,
  parameter int UNLOCK_TH = DEF_UNLOCK_TH,
  parameter int LOCK_CNT  = DEF_LOCK_CNT
) (
  input  logic             CLK_SYS,
  input  logic             CLK_RST,
  input  logic [ABS_W-1:0] i_abs_err,
  input  logic             i_coarse,
  input  logic             i_eval,
  output logic             o_lock
);

  localparam int                CNT_W      = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [ABS_W-1:0]  LOCK_LIM   = ABS_W'(LOCK_TH);
  localparam logic [ABS_W-1:0]  UNLOCK_LIM = ABS_W'(UNLOCK_TH);

  logic [CNT_W-1:0] r_cnt;
  logic             r_lock;
  logic             w_out_window;
  logic             w_in_window;

  assign w_out_window = i_coarse || (i_abs_err > UNLOCK_LIM);
  assign w_in_window  = (i_abs_err <= LOCK_LIM);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      r_cnt  <= '0;
      r_lock <= 1'b0;
    end else if (i_eval) begin
      if (w_out_window) begin
        r_cnt  <= '0;
        r_lock <= 1'b0;
      end else if (w_in_window) begin
        if (r_cnt != CNT_FULL) r_cnt <= r_cnt + CNT_ONE;
        if (r_cnt >= CNT_FULL - CNT_ONE) r_lock <= 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_lock = r_lock;

endmodule

// File: rtl/pid_loop_filter.sv
// PI loop filter for OCXO steering: multi-cycle datapath turning each phase error
// into a saturated PWM duty, with integrator anti-windup and a lock indicator.
module pid_loop_filter
  import pid_pkg::*;
#(
  parameter int PHASE_W         = DEF_PHASE_W,
  parameter int DUTY_W          = DEF_DUTY_W,
  parameter int DUTY_CENTER     = DEF_DUTY_CENTER,
  parameter int DUTY_MIN        = DEF_DUTY_MIN,
  parameter int DUTY_MAX        = DEF_DUTY_MAX,
  parameter int KP_SHIFT        = DEF_KP_SHIFT,
  parameter int KP_COARSE_SHIFT = DEF_KP_COARSE_SHIFT,
  parameter int KI_SHIFT        = DEF_KI_SHIFT,
  parameter int ERR_CLAMP       = DEF_ERR_CLAMP,
  parameter int COARSE_TH       = DEF_COARSE_TH,
  parameter int LOCK_TH         = DEF_LOCK_TH,
  parameter int UNLOCK_TH       = DEF_UNLOCK_TH,
  parameter int LOCK_CNT        = DEF_LOCK_CNT
) (
  input  logic              CLK_SYS,
  input  logic              CLK_RST,
  pid_loop_filter_if.slave  meas,
  output logic [DUTY_W-1:0] PWM_Duty,
  output logic              Duty_Valid,
  output logic              Led_Lock,
  output logic              Busy,
  output logic              Overrun
);

  localparam int ABS_W  = PHASE_W + 1;
  localparam int ACC_W  = acc_width(DUTY_W, KI_SHIFT);
  localparam int ACCX_W = ACC_W + 1;
  localparam int SUM_W  = ((PHASE_W > ACC_W) ? PHASE_W : ACC_W) + 2;

  localparam logic signed [PHASE_W-1:0] ERRC_HI    = PHASE_W'(ERR_CLAMP);
  localparam logic signed [PHASE_W-1:0] ERRC_LO    = PHASE_W'(-ERR_CLAMP);
  localparam logic        [ABS_W-1:0]   COARSE_LIM = ABS_W'(COARSE_TH);
  localparam logic signed [ACCX_W-1:0]  ACC_HI     = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACCX_W-1:0]  ACC_LO     = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0]   S_CENTER   = SUM_W'(DUTY_CENTER);
  localparam logic signed [SUM_W-1:0]   S_MIN      = SUM_W'(DUTY_MIN);
  localparam logic signed [SUM_W-1:0]   S_MAX      = SUM_W'(DUTY_MAX);

  pid_state_e                r_state;
  pid_state_e                w_state_next;

  logic signed [PHASE_W-1:0] r_err;
  logic signed [PHASE_W-1:0] r_errc;
  logic        [ABS_W-1:0]   r_abs;
  logic                      r_coarse;
  logic signed [ACC_W-1:0]   r_acc;
  logic        [DUTY_W-1:0]  r_duty;
  logic                      r_sat_hi;
  logic                      r_sat_lo;
  logic                      r_overrun;

  logic                      w_accept;
  logic                      w_do_clamp;
  logic                      w_do_integ;
  logic                      w_do_sum;

  logic signed [ABS_W-1:0]   w_err_x;
  logic        [ABS_W-1:0]   w_abs;
  logic                      w_coarse;
  logic signed [PHASE_W-1:0] w_errc;
  logic                      w_acc_hold;
  logic signed [ACCX_W-1:0]  w_acc_sum;
  logic signed [ACC_W-1:0]   w_acc_next;
  logic signed [PHASE_W-1:0] w_p;
  logic signed [ACC_W-1:0]   w_i;
  logic signed [SUM_W-1:0]   w_sum;
  logic                      w_sat_hi;
  logic                      w_sat_lo;
  logic        [DUTY_W-1:0]  w_duty_clamped;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: the default assignment up front keeps every path driven, so no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (meas.Measure_Done) w_state_next = ST_CLAMP;
      ST_CLAMP: w_state_next = ST_INTEG;
      ST_INTEG: w_state_next = ST_SUM;
      ST_SUM:   w_state_next = ST_OUT;
      ST_OUT:   w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // The SUM step commits duty and lock on its exit edge, so both are new while Duty_Valid is high.
  always_comb begin
    Busy       = (r_state != ST_IDLE);
    Duty_Valid = (r_state == ST_OUT);
    w_accept   = (r_state == ST_IDLE) && meas.Measure_Done;
    w_do_clamp = (r_state == ST_CLAMP);
    w_do_integ = (r_state == ST_INTEG);
    w_do_sum   = (r_state == ST_SUM);
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    // One extra bit so the magnitude of the most negative error is representable.
    w_err_x = ABS_W'(r_err);
    w_abs   = w_err_x[ABS_W-1] ? ABS_W'(-w_err_x) : ABS_W'(w_err_x);
    w_coarse = (w_abs > COARSE_LIM);

    if (r_err > ERRC_HI)      w_errc = ERRC_HI;
    else if (r_err < ERRC_LO) w_errc = ERRC_LO;
    else                      w_errc = r_err;

    w_acc_hold = r_coarse
              || (r_sat_hi && !r_errc[PHASE_W-1] && (r_errc != '0))
              || (r_sat_lo &&  r_errc[PHASE_W-1]);

    w_acc_sum = ACCX_W'(r_acc) + ACCX_W'(r_errc);
    if (w_acc_sum > ACC_HI)      w_acc_next = ACC_HI[ACC_W-1:0];
    else if (w_acc_sum < ACC_LO) w_acc_next = ACC_LO[ACC_W-1:0];
    else                         w_acc_next = w_acc_sum[ACC_W-1:0];

    w_p   = r_coarse ? (r_errc >>> KP_COARSE_SHIFT) : (r_errc >>> KP_SHIFT);
    w_i   = r_acc >>> KI_SHIFT;
    w_sum = S_CENTER + SUM_W'(w_p) + SUM_W'(w_i);

    w_sat_hi = (w_sum > S_MAX);
    w_sat_lo = (w_sum < S_MIN);
    if (w_sat_hi)      w_duty_clamped = DUTY_W'(DUTY_MAX);
    else if (w_sat_lo) w_duty_clamped = DUTY_W'(DUTY_MIN);
    else               w_duty_clamped = w_sum[DUTY_W-1:0];
  end

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      r_err     <= '0;
      r_errc    <= '0;
      r_abs     <= '0;
      r_coarse  <= 1'b0;
      r_acc     <= '0;
      r_duty    <= DUTY_W'(DUTY_CENTER);
      r_sat_hi  <= 1'b0;
      r_sat_lo  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= meas.Measure_Done && Busy;
      if (w_accept) r_err <= meas.Measure_Phase;
      if (w_do_clamp) begin
        r_abs    <= w_abs;
        r_coarse <= w_coarse;
        r_errc   <= w_errc;
      end
      if (w_do_integ && !w_acc_hold) r_acc <= w_acc_next;
      if (w_do_sum) begin
        r_duty   <= w_duty_clamped;
        r_sat_hi <= w_sat_hi;
        r_sat_lo <= w_sat_lo;
      end
    end
  end

  pid_lock_detect #(
    .ABS_W     (ABS_W),
    .LOCK_TH   (LOCK_TH),
    .UNLOCK_TH (UNLOCK_TH),
    .LOCK_CNT  (LOCK_CNT)
  ) u_lock_detect (
    .CLK_SYS   (CLK_SYS),
    .CLK_RST   (CLK_RST),
    .i_abs_err (r_abs),
    .i_coarse  (r_coarse),
    .i_eval    (w_do_sum),
    .o_lock    (Led_Lock)
  );

  assign PWM_Duty = r_duty;
  assign Overrun  = r_overrun;

endmodule

// File: tb/tb_pid_loop_filter.sv
// Scoreboard bench for pid_loop_filter: directed phase errors with hand-computed duties;
// a negedge monitor pops and checks each Duty_Valid against the queue.
module tb_pid_loop_filter;
  import pid_pkg::*;

  typedef struct {
    int    duty;
    bit    lock;
    int    cyc;
    string name;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] pwm;
  logic        dv, lock, busy, ovr;

  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   ovr_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pid_loop_filter_if #(.PHASE_W(DEF_PHASE_W)) meas_if ();

  pid_loop_filter dut (
    .CLK_SYS    (clk),
    .CLK_RST    (rst_n),
    .meas       (meas_if),
    .PWM_Duty   (pwm),
    .Duty_Valid (dv),
    .Led_Lock   (lock),
    .Busy       (busy),
    .Overrun    (ovr)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every Duty_Valid must match the oldest expected result, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && dv) begin
      if (sb.size() == 0) begin
        check("unexpected_duty_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_duty"}, int'(pwm), e.duty);
        check({e.name, "_lock"}, int'(lock), int'(e.lock));
        check({e.name, "_latency"}, cyc, e.cyc);
      end
    end
    if (ovr) ovr_cnt++;
  end

  task automatic set_phase(input int v);
    meas_if.Measure_Phase = v[DEF_PHASE_W-1:0];
  endtask

  task automatic push_exp(input int duty, input bit lk, input string name);
    exp_t e;
    e = '{duty: duty, lock: lk, cyc: cyc + 4, name: name};
    sb.push_back(e);
  endtask

  // One strobe, then idle until the OUT cycle; the next call strobes in the following IDLE cycle.
  task automatic send(input int err, input int exp_duty, input bit exp_lock, input string name);
    @(negedge clk);
    set_phase(err);
    meas_if.Measure_Done = 1'b1;
    push_exp(exp_duty, exp_lock, name);
    @(negedge clk);
    meas_if.Measure_Done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, sb.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    meas_if.Measure_Done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    meas_if.Measure_Done  = 1'b0;
    meas_if.Measure_Phase = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_duty",  int'(pwm),  35000);
    check("reset_valid", int'(dv),   0);
    check("reset_lock",  int'(lock), 0);
    check("reset_busy",  int'(busy), 0);
    check("reset_ovr",   int'(ovr),  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic P + I response, both signs (i floors toward -inf).
    send(160, 35010, 1'b0, "t1_pos160");
    drain("t1_drain");
    do_reset();
    send(-160, 34989, 1'b0, "t2_neg160");
    drain("t2_drain");

    // Coarse mode: larger P gain, integrator frozen.
    do_reset();
    for (int k = 0; k < 10; k++) send(5000001, 64000, 1'b0, "t3_coarse");
    send(0, 35000, 1'b0, "t3_acc_frozen");
    do_reset();
    send(5000000, 64000, 1'b0, "t3_at_coarse_th");
    send(0, 39095, 1'b0, "t3_th_integrated");
    do_reset();
    send(-8388608, 1000, 1'b0, "t3_most_negative");
    send(0, 35000, 1'b0, "t3_neg_frozen");
    drain("t3_drain");

    // Anti-windup at the top and bottom rails.
    do_reset();
    send(1048575, 64000, 1'b0, "t4_sat_hi");
    send(1000, 39157, 1'b0, "t4_windup_blocked");
    send(1000, 39161, 1'b0, "t4_integrating");
    send(-1000, 39032, 1'b0, "t4_decrement");
    do_reset();
    send(-1048575, 1000, 1'b0, "t4_sat_lo");
    send(-1000, 30841, 1'b0, "t4_lo_blocked");
    send(-1000, 30837, 1'b0, "t4_lo_integrating");
    drain("t4_drain");

    // Lock: 16 in-window samples, hysteresis band holds, above UNLOCK_TH drops.
    do_reset();
    for (int n = 1; n <= 16; n++) send(50, 35003 + (50 * n) / 256, n == 16, "t5_lock_ramp");
    send(500, 35036, 1'b1, "t5_hyst_hold");
    send(1001, 35070, 1'b0, "t5_unlock");
    do_reset();
    for (int n = 1; n <= 16; n++)
      send((n % 2 == 1) ? 100 : -100, (n % 2 == 1) ? 35006 : 34993, n == 16, "t5_lock_th_edge");
    send(101, 35006, 1'b1, "t5_just_above_lock_th");
    send(1000, 35066, 1'b1, "t5_at_unlock_th");
    drain("t5_drain");

    // Reset while a sample is in INTEG: everything back to reset values, no Duty_Valid.
    @(negedge clk);
    set_phase(1000);
    meas_if.Measure_Done = 1'b1;
    @(negedge clk);
    meas_if.Measure_Done = 1'b0;
    @(negedge clk);
    check("t7_busy_in_integ", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_duty",  int'(pwm),  35000);
    check("t7_rst_lock",  int'(lock), 0);
    check("t7_rst_valid", int'(dv),   0);
    check("t7_rst_busy",  int'(busy), 0);
    check("t7_rst_ovr",   int'(ovr),  0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    send(160, 35010, 1'b0, "t7_integ_cleared");
    drain("t7_drain");

    // Overrun: strobes during CLAMP-INTEG and during OUT are dropped.
    do_reset();
    ovr_cnt = 0;
    @(negedge clk);
    set_phase(160);
    meas_if.Measure_Done = 1'b1;
    push_exp(35010, 1'b0, "t6_first");
    @(negedge clk);
    meas_if.Measure_Done = 1'b0;
    @(negedge clk);
    set_phase(9999);
    meas_if.Measure_Done = 1'b1;
    check("t6_busy", int'(busy), 1);
    @(negedge clk);
    meas_if.Measure_Done = 1'b0;
    check("t6_overrun_pulse1", int'(ovr), 1);
    @(negedge clk);
    set_phase(-5000);
    meas_if.Measure_Done = 1'b1;
    @(negedge clk);
    meas_if.Measure_Done = 1'b0;
    check("t6_overrun_pulse2", int'(ovr), 1);
    @(negedge clk);
    check("t6_overrun_clear", int'(ovr), 0);
    drain("t6_drain");
    check("t6_overrun_count", ovr_cnt, 2);
    send(0, 35000, 1'b0, "t6_acc_intact");
    drain("t6_final_drain");

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
